// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: state encoding, master indices and default sizes for the ROM arbiter
package rom_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  localparam int CNT_W = 8;
  localparam int TIMEOUT_DEF = 15;
  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: both master request channels plus the ROM slave bus
interface rom_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              m0_req_, m1_req_;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_rd_data, m1_rd_data;
  logic              m0_rdy_, m1_rdy_, m0_err_, m1_err_;
  logic              rom_cs_, rom_as_, rom_rdy_;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rd_data;
  modport slave (
    input  m0_req_, m1_req_, m0_addr, m1_addr, rom_rd_data, rom_rdy_,
    output m0_rd_data, m1_rd_data, m0_rdy_, m1_rdy_, m0_err_, m1_err_, rom_cs_, rom_as_, rom_addr
  );
  modport master (
    output m0_req_, m1_req_, m0_addr, m1_addr, rom_rd_data, rom_rdy_,
    input  m0_rd_data, m1_rd_data, m0_rdy_, m1_rdy_, m0_err_, m1_err_, rom_cs_, rom_as_, rom_addr
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin two-master access sequencer for the single-port ROM with timeout
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic          clk,
  input logic          reset,
  rom_arbiter_if.slave bus
);
  state_t            state, state_d;
  logic              gnt, gnt_d, last, last_d, cs_q;
  logic              r0, r1, rdy, tmo, done, pick;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rd_data;
  assign rd_data = bus.rom_rd_data;
  always_comb begin
    r0 = !bus.m0_req_;
    r1 = !bus.m1_req_;
    rdy = state == WAIT && !bus.rom_rdy_;
    tmo = state == WAIT && bus.rom_rdy_ && cnt == CNT_W'(TIMEOUT - 1);
    done = rdy || tmo;
    pick = (r0 && r1) ? !last : !r0;
    state_d = state;
    gnt_d = gnt;
    last_d = last;
    if (state == IDLE && (r0 || r1)) begin
      state_d = REQ;
      gnt_d = pick;
    end else if (state == REQ) begin
      state_d = WAIT;
    end else if (done) begin
      // the served master's own request is ignored in its completion cycle
      last_d = gnt;
      state_d = (gnt ? r0 : r1) ? REQ : IDLE;
      gnt_d = !gnt;
    end
    addr_d = gnt_d ? bus.m1_addr : bus.m0_addr;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt <= M0;
      last <= M1;
      cnt <= '0;
      cs_q <= 1'b1;
      addr_q <= '0;
    end else begin
      state <= state_d;
      gnt <= gnt_d;
      last <= last_d;
      cnt <= state == REQ ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
      cs_q <= state_d != REQ;
      addr_q <= state_d == REQ ? addr_d : addr_q;
    end
  end
  assign bus.rom_cs_    = cs_q;
  assign bus.rom_as_    = cs_q;
  assign bus.rom_addr   = addr_q;
  assign bus.m0_rdy_    = !(rdy && gnt == M0);
  assign bus.m1_rdy_    = !(rdy && gnt == M1);
  assign bus.m0_err_    = !(tmo && gnt == M0);
  assign bus.m1_err_    = !(tmo && gnt == M1);
  assign bus.m0_rd_data = (rdy && gnt == M0) ? rd_data : '0;
  assign bus.m1_rd_data = (rdy && gnt == M1) ? rd_data : '0;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed and randomized checks of rom_arbiter against a transaction-level model
module tb_rom_arbiter;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rom_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus ();
  rom_arbiter #(.ADDR_W(11), .DATA_W(32), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic        req_n [2];
  logic [10:0] addr  [2];
  logic        rom_rdy_n;
  logic [31:0] rom_dat;
  assign bus.m0_req_     = req_n[0];
  assign bus.m1_req_     = req_n[1];
  assign bus.m0_addr     = addr[0];
  assign bus.m1_addr     = addr[1];
  assign bus.rom_rdy_    = rom_rdy_n;
  assign bus.rom_rd_data = rom_dat;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  // model: ms 0 = no access, 1 = strobe cycle, 2 = waiting for ROM
  int ms = 0, who = 0, last = 1, waited = 0;
  logic [10:0] m_addr = '0;
  bit mute = 0, dly_en = 0, spur_en = 0, spur_force = 0, auto_req = 0;
  bit hold [2] = '{0, 0};
  bit rom_pend = 0;
  int rom_cnt = 0;
  logic [10:0] rom_a = '0;
  int rdy_cyc [2], err_cyc [2], n_done [2], n_err [2];
  logic [31:0] rdy_dat [2];
  int strobe_cyc, n_strobe;

  function automatic logic [31:0] mem(input logic [10:0] a);
    return a == 11'h005 ? 32'hDEADBEEF : {a, 21'h0} ^ (32'h9E3779B9 * {21'h0, a});
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rdy_cyc = '{-1, -1};
    err_cyc = '{-1, -1};
    n_done = '{0, 0};
    n_err = '{0, 0};
    rdy_dat = '{0, 0};
    strobe_cyc = -1;
    n_strobe = 0;
  endtask

  task automatic model_reset();
    ms = 0; who = 0; last = 1; waited = 0; m_addr = '0; rom_pend = 0;
  endtask

  task automatic step();
    logic [1:0]  e_rdy, e_err;
    logic [31:0] e_dat [2];
    bit          done [2];
    @(negedge clk);
    if (mute) begin
      rom_rdy_n = 1'b1;
      rom_dat = $urandom;
    end else if (rom_pend && rom_cnt == 0) begin
      rom_rdy_n = 1'b0;
      rom_dat = mem(rom_a);
      rom_pend = 0;
    end else begin
      if (rom_pend) rom_cnt--;
      rom_rdy_n = !(!rom_pend && (spur_force || (spur_en && $urandom_range(0, 5) == 0)));
      rom_dat = $urandom;
    end
    #1;
    e_rdy = 2'b11;
    e_err = 2'b11;
    e_dat[0] = '0;
    e_dat[1] = '0;
    if (ms == 2 && !rom_rdy_n) begin
      e_rdy[who] = 1'b0;
      e_dat[who] = mem(m_addr);
    end else if (ms == 2 && waited == TO - 1) e_err[who] = 1'b0;
    check("m0_out", {bus.m0_rdy_, bus.m0_err_, bus.m0_rd_data}, {e_rdy[0], e_err[0], e_dat[0]});
    check("m1_out", {bus.m1_rdy_, bus.m1_err_, bus.m1_rd_data}, {e_rdy[1], e_err[1], e_dat[1]});
    check("rom_out", {bus.rom_cs_, bus.rom_as_, bus.rom_addr}, {ms != 1, ms != 1, m_addr});
    if (!bus.m0_rdy_) begin rdy_cyc[0] = cyc; rdy_dat[0] = bus.m0_rd_data; n_done[0]++; end
    if (!bus.m1_rdy_) begin rdy_cyc[1] = cyc; rdy_dat[1] = bus.m1_rd_data; n_done[1]++; end
    if (!bus.m0_err_) begin err_cyc[0] = cyc; n_err[0]++; end
    if (!bus.m1_err_) begin err_cyc[1] = cyc; n_err[1]++; end
    if (!bus.rom_cs_) begin
      strobe_cyc = cyc;
      n_strobe++;
      if (!mute) begin
        rom_pend = 1;
        rom_a = bus.rom_addr;
        rom_cnt = (dly_en && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      end
    end
    done[0] = 0;
    done[1] = 0;
    if (ms == 0) begin
      if (!req_n[0] || !req_n[1]) begin
        who = (!req_n[0] && !req_n[1]) ? 1 - last : (req_n[0] ? 1 : 0);
        m_addr = addr[who];
        ms = 1;
      end
    end else if (ms == 1) begin
      ms = 2;
      waited = 0;
    end else if (!rom_rdy_n || waited == TO - 1) begin
      done[who] = 1;
      last = who;
      if (!req_n[1 - who]) begin
        who = 1 - who;
        m_addr = addr[who];
        ms = 1;
      end else ms = 0;
    end else waited++;
    @(posedge clk);
    cyc++;
    #1;
    for (int n = 0; n < 2; n++) begin
      if (done[n]) begin
        if (hold[n]) addr[n] = 11'($urandom);
        else req_n[n] = 1'b1;
      end else if (auto_req && req_n[n] && $urandom_range(0, 3) == 0) begin
        req_n[n] = 1'b0;
        addr[n] = 11'($urandom);
      end
    end
  endtask

  initial begin
    int k;
    req_n = '{1'b1, 1'b1};
    addr = '{11'h0, 11'h0};
    rom_rdy_n = 1'b1;
    rom_dat = '0;
    clr();
    @(posedge clk);
    #1;
    check("rst_m0", {bus.m0_rdy_, bus.m0_err_, bus.m0_rd_data}, {1'b1, 1'b1, 32'h0});
    check("rst_m1", {bus.m1_rdy_, bus.m1_err_, bus.m1_rd_data}, {1'b1, 1'b1, 32'h0});
    check("rst_rom", {bus.rom_cs_, bus.rom_as_, bus.rom_addr}, {1'b1, 1'b1, 11'h0});
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // simultaneous requests: m0 wins the first tie, then the next tie after m1 was served
    clr();
    k = cyc;
    req_n = '{1'b0, 1'b0};
    addr = '{11'h010, 11'h020};
    repeat (6) step();
    check("tie_m0_rdy_cyc", rdy_cyc[0], k + 2);
    check("tie_m1_rdy_cyc", rdy_cyc[1], k + 4);
    check("tie_m1_strobe_cyc", strobe_cyc, k + 3);
    check("tie_m0_data", rdy_dat[0], mem(11'h010));
    check("tie_m1_data", rdy_dat[1], mem(11'h020));
    clr();
    k = cyc;
    req_n = '{1'b0, 1'b0};
    addr = '{11'h030, 11'h040};
    repeat (6) step();
    check("tie2_m0_rdy_cyc", rdy_cyc[0], k + 2);
    check("tie2_m1_rdy_cyc", rdy_cyc[1], k + 4);

    // single read from m0
    clr();
    k = cyc;
    req_n[0] = 1'b0;
    addr[0] = 11'h005;
    repeat (4) step();
    check("single_strobes", n_strobe, 1);
    check("single_strobe_cyc", strobe_cyc, k + 1);
    check("single_rdy_cyc", rdy_cyc[0], k + 2);
    check("single_data", rdy_dat[0], 32'hDEADBEEF);
    check("single_m1_idle", n_done[1] + n_err[1], 0);

    // m0 streams requests, m1 asks once and must not starve
    clr();
    hold[0] = 1;
    req_n[0] = 1'b0;
    addr[0] = 11'h100;
    repeat (3) step();
    clr();
    req_n[1] = 1'b0;
    addr[1] = 11'h200;
    for (int i = 0; i < 20 && n_done[1] == 0; i++) step();
    check("fair_m1_served", n_done[1], 1);
    check("fair_m0_before_m1", n_done[0] <= 1, 1);
    check("fair_m1_data", rdy_dat[1], mem(11'h200));
    hold[0] = 0;
    repeat (6) step();

    // silent ROM: timeout error, then a normal access
    clr();
    mute = 1;
    k = cyc;
    req_n[0] = 1'b0;
    addr[0] = 11'h033;
    repeat (20) step();
    check("tmo_err_cyc", err_cyc[0], k + 16);
    check("tmo_err_count", n_err[0], 1);
    check("tmo_no_rdy", n_done[0], 0);
    mute = 0;
    clr();
    k = cyc;
    req_n[0] = 1'b0;
    addr[0] = 11'h044;
    repeat (4) step();
    check("after_tmo_rdy_cyc", rdy_cyc[0], k + 2);
    check("after_tmo_data", rdy_dat[0], mem(11'h044));

    // reset while waiting: outputs drop to reset values at once, no pulse
    clr();
    req_n[1] = 1'b0;
    addr[1] = 11'h077;
    repeat (2) step();
    #1;
    rom_rdy_n = 1'b0;
    rom_dat = 32'hCAFEF00D;
    reset = 1'b0;
    #1;
    check("arst_m0", {bus.m0_rdy_, bus.m0_err_, bus.m0_rd_data}, {1'b1, 1'b1, 32'h0});
    check("arst_m1", {bus.m1_rdy_, bus.m1_err_, bus.m1_rd_data}, {1'b1, 1'b1, 32'h0});
    check("arst_rom", {bus.rom_cs_, bus.rom_as_, bus.rom_addr}, {1'b1, 1'b1, 11'h0});
    model_reset();
    @(posedge clk);
    #1;
    check("arst_hold_rom", {bus.rom_cs_, bus.m1_rdy_}, {1'b1, 1'b1});
    @(negedge clk);
    reset = 1'b1;
    req_n[1] = 1'b1;
    rom_rdy_n = 1'b1;
    clr();
    spur_force = 1;
    repeat (3) step();
    spur_force = 0;
    check("spurious_not_forwarded", n_done[0] + n_done[1], 0);

    // randomized traffic with variable ROM latency and spurious ready
    clr();
    auto_req = 1;
    dly_en = 1;
    spur_en = 1;
    repeat (1500) step();
    auto_req = 0;
    spur_en = 0;
    repeat (12) step();
    check("rnd_m0_served", n_done[0] > 0, 1);
    check("rnd_m1_served", n_done[1] > 0, 1);
    check("rnd_no_timeouts", n_err[0] + n_err[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
